bc_datapath_io: RTL and testbench
=================================

BC_DATAPATH_IO -- requirements
Module: bc_datapath_io

Interface
REQ-001 SHALL have parameter WORD, default 16, data word width.
REQ-002 SHALL have parameter ADDRESS, default 12, address width, ADDRESS <= WORD.
REQ-003 SHALL have parameter SIZE, default 4096, memory depth, SIZE <= 2^ADDRESS.
REQ-004 SHALL have parameter IO_W, default 8, I/O character width, IO_W <= WORD.
REQ-005 SHALL have ports:
- clk  in  1  single clock, all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sel_bus  in  3  bus source select.
- sel_alu  in  3  ALU op select.
- ld  in  6  load enables; bit0..5 = AR, PC, DR, AC, IR, TR.
- clr  in  6  clear enables, same bit order.
- inr  in  6  increment enables, same bit order.
- mem_we  in  1  memory write.
- e_ld, e_clr, e_cme  in  1 each  E load from ALU carry / clear / complement.
- ien_set, ien_clr  in  1 each  interrupt enable control.
- int_sample  in  1  control unit window for setting R.
- r_clr  in  1  interrupt-cycle acknowledge.
- fgi_clr, outr_ld  in  1 each  INP / OUT instruction strobes.
- in_data  in  IO_W; in_valid  in  1; in_ready  out  1  input handshake.
- out_data  out  IO_W; out_valid  out  1; out_ready  in  1  output handshake.
- bus_out, ac_out, dr_out, ir_out  out  WORD  observation.
- pc_out, ar_out  out  ADDRESS  observation.
- e_out, ien_out, r_out, fgi_out, fgo_out  out  1  flag state.
- ac_zero, ac_neg, dr_zero  out  1  combinational status.

Function
REQ-006 Bus SHALL select: 0 zero, 1 AR, 2 PC (both zero-extended), 3 DR, 4 AC, 5 IR, 6 TR, 7 M[AR].
REQ-007 Per register, priority SHALL be clr > ld > inr; inr wraps modulo 2^width.
REQ-008 AR and PC SHALL load bus[ADDRESS-1:0]; DR, IR, TR load bus; AC loads ALU result.
REQ-009 ALU SHALL compute: 0 AC&DR, 1 AC+DR (carry out to cout), 2 DR, 3 {AC[WORD-1:IO_W], INPR}, 4 ~AC, 5 {E, AC[WORD-1:1]} (cout = AC[0]), 6 {AC[WORD-2:0], E} (cout = AC[WORD-1]), 7 AC.
REQ-010 E SHALL update with priority e_clr > e_cme > e_ld (E <= cout).
REQ-011 Memory SHALL write bus to M[AR] on edge when mem_we; reads combinational; memory contents not reset.
REQ-012 in_ready SHALL equal ~FGI; when in_valid & in_ready, INPR <= in_data and FGI <= 1.
REQ-013 fgi_clr SHALL clear FGI; fgi_clr while FGI=0 is a no-op.
REQ-014 out_valid SHALL equal ~FGO and out_data SHALL equal OUTR.
REQ-015 outr_ld with FGO=1 SHALL set OUTR <= AC[IO_W-1:0] and FGO <= 0; outr_ld with FGO=0 is ignored.
REQ-016 out_valid & out_ready SHALL set FGO <= 1 on that edge.
REQ-017 IEN priority SHALL be ien_clr > ien_set.
REQ-018 R SHALL set when int_sample & IEN & (FGI | FGO) & ~r_clr; r_clr clears R with priority.
REQ-019 ac_zero = (AC==0), ac_neg = AC[WORD-1], dr_zero = (DR==0), all combinational.

Reset
REQ-020 reset_n low SHALL immediately force AR, PC, DR, AC, IR, TR, E, IEN, R, FGI, INPR, OUTR to 0 and FGO to 1, mid-handshake included.
REQ-021 After reset, in_ready=1 and out_valid=0; memory SHALL be unchanged.

Verification
REQ-022 Reset asserted mid-operation with AC=0x1234 and FGO=0 -> AC=0, FGO=1 and out_valid=0 before next clk edge.
REQ-023 PC=0xFFF with inr[1] -> PC=0x000; same cycle ld[1] and inr[1] with bus=0x005 -> PC=0x005.
REQ-024 AC=0xFFFF, DR=0x0001, sel_alu=1, ld[3], e_ld -> AC=0x0000, E=1, ac_zero=1.
REQ-025 in_data=0x41, in_valid=1 -> FGI=1, in_ready=0; sel_alu=3, ld[3] with AC=0 -> AC=0x0041; second in_valid held, not accepted until fgi_clr.
REQ-026 AC=0x0042, outr_ld -> out_valid=1, out_data=0x42; a second outr_ld is ignored; out_ready=1 -> FGO=1, out_valid=0.
REQ-027 IEN=1, FGI=1, int_sample=1 -> R=1; int_sample and r_clr in the same cycle -> R=0.

Source files
------------

// File: rtl/bc_datapath_io.sv
// bc_datapath_io: datapath of a basic accumulator computer with a character
// I/O port.
//
// Parameters: WORD (data width), ADDRESS (address width), SIZE (memory depth),
// IO_W (character width).
//
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   sel_bus, sel_alu        - common bus source / ALU operation select
//   ld, clr, inr            - per-register load/clear/increment enables,
//                             bit order AR, PC, DR, AC, IR, TR
//   mem_we                  - write bus into M[AR]
//   e_ld, e_clr, e_cme      - E flip-flop control
//   ien_set, ien_clr        - interrupt enable control
//   int_sample, r_clr       - interrupt request sampling / acknowledge
//   fgi_clr, outr_ld        - INP / OUT instruction strobes
//   in_data/in_valid/in_ready     - input character handshake
//   out_data/out_valid/out_ready  - output character handshake
//   bus_out, ac_out, dr_out, ir_out, pc_out, ar_out - register observation
//   e_out, ien_out, r_out, fgi_out, fgo_out         - flag observation
//   ac_zero, ac_neg, dr_zero                        - combinational status
module bc_datapath_io #(
  parameter int WORD    = 16,
  parameter int ADDRESS = 12,
  parameter int SIZE    = 4096,
  parameter int IO_W    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         sel_bus,
  input  logic [2:0]         sel_alu,
  input  logic [5:0]         ld,
  input  logic [5:0]         clr,
  input  logic [5:0]         inr,
  input  logic               mem_we,
  input  logic               e_ld,
  input  logic               e_clr,
  input  logic               e_cme,
  input  logic               ien_set,
  input  logic               ien_clr,
  input  logic               int_sample,
  input  logic               r_clr,
  input  logic               fgi_clr,
  input  logic               outr_ld,
  input  logic [IO_W-1:0]    in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [IO_W-1:0]    out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD-1:0]    bus_out,
  output logic [WORD-1:0]    ac_out,
  output logic [WORD-1:0]    dr_out,
  output logic [WORD-1:0]    ir_out,
  output logic [ADDRESS-1:0] pc_out,
  output logic [ADDRESS-1:0] ar_out,
  output logic               e_out,
  output logic               ien_out,
  output logic               r_out,
  output logic               fgi_out,
  output logic               fgo_out,
  output logic               ac_zero,
  output logic               ac_neg,
  output logic               dr_zero
);

  localparam int R_AR = 0;
  localparam int R_PC = 1;
  localparam int R_DR = 2;
  localparam int R_AC = 3;
  localparam int R_IR = 4;
  localparam int R_TR = 5;

  logic [ADDRESS-1:0] ar, pc;
  logic [WORD-1:0]    dr, ac, ir, tr;
  logic               e, ien, r, fgi, fgo;
  logic [IO_W-1:0]    inpr, outr;

  logic [WORD-1:0]    mem [SIZE];
  logic [WORD-1:0]    mem_rd;
  logic [WORD-1:0]    bus;
  logic [WORD-1:0]    alu_res;
  logic               cout;
  logic [WORD:0]      sum;

  // Addresses beyond the populated depth read as zero.
  assign mem_rd = (32'(ar) < SIZE) ? mem[ar] : '0;

  always_comb begin
    bus = '0;
    case (sel_bus)
      3'd0: bus = '0;
      3'd1: bus = WORD'(ar);
      3'd2: bus = WORD'(pc);
      3'd3: bus = dr;
      3'd4: bus = ac;
      3'd5: bus = ir;
      3'd6: bus = tr;
      3'd7: bus = mem_rd;
      default: bus = '0;
    endcase
  end

  // ALU; cout is meaningful only for add and the two rotates.
  always_comb begin
    alu_res = ac;
    cout    = 1'b0;
    sum     = '0;
    case (sel_alu)
      3'd0: alu_res = ac & dr;
      3'd1: begin
        sum     = {1'b0, ac} + {1'b0, dr};
        alu_res = sum[WORD-1:0];
        cout    = sum[WORD];
      end
      3'd2: alu_res = dr;
      3'd3: begin
        alu_res            = ac;
        alu_res[IO_W-1:0]  = inpr;
      end
      3'd4: alu_res = ~ac;
      3'd5: begin
        alu_res = {e, ac[WORD-1:1]};
        cout    = ac[0];
      end
      3'd6: begin
        alu_res = {ac[WORD-2:0], e};
        cout    = ac[WORD-1];
      end
      3'd7: alu_res = ac;
      default: alu_res = ac;
    endcase
  end

  // Register file: clear beats load beats increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ar <= '0;
      pc <= '0;
      dr <= '0;
      ac <= '0;
      ir <= '0;
      tr <= '0;
    end else begin
      if (clr[R_AR])      ar <= '0;
      else if (ld[R_AR])  ar <= bus[ADDRESS-1:0];
      else if (inr[R_AR]) ar <= ar + ADDRESS'(1);

      if (clr[R_PC])      pc <= '0;
      else if (ld[R_PC])  pc <= bus[ADDRESS-1:0];
      else if (inr[R_PC]) pc <= pc + ADDRESS'(1);

      if (clr[R_DR])      dr <= '0;
      else if (ld[R_DR])  dr <= bus;
      else if (inr[R_DR]) dr <= dr + WORD'(1);

      if (clr[R_AC])      ac <= '0;
      else if (ld[R_AC])  ac <= alu_res;
      else if (inr[R_AC]) ac <= ac + WORD'(1);

      if (clr[R_IR])      ir <= '0;
      else if (ld[R_IR])  ir <= bus;
      else if (inr[R_IR]) ir <= ir + WORD'(1);

      if (clr[R_TR])      tr <= '0;
      else if (ld[R_TR])  tr <= bus;
      else if (inr[R_TR]) tr <= tr + WORD'(1);
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we && (32'(ar) < SIZE)) mem[ar] <= bus;
  end

  // Flags and I/O registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e    <= 1'b0;
      ien  <= 1'b0;
      r    <= 1'b0;
      fgi  <= 1'b0;
      fgo  <= 1'b1;
      inpr <= '0;
      outr <= '0;
    end else begin
      if (e_clr)      e <= 1'b0;
      else if (e_cme) e <= ~e;
      else if (e_ld)  e <= cout;

      if (ien_clr)      ien <= 1'b0;
      else if (ien_set) ien <= 1'b1;

      if (r_clr)                                  r <= 1'b0;
      else if (int_sample && ien && (fgi || fgo)) r <= 1'b1;

      // Accept and clear are exclusive: accept needs FGI=0, clear only
      // changes anything when FGI=1.
      if (in_valid && !fgi) begin
        inpr <= in_data;
        fgi  <= 1'b1;
      end else if (fgi_clr) begin
        fgi  <= 1'b0;
      end

      // A new character is taken only once the previous one has drained.
      if (outr_ld && fgo) begin
        outr <= ac[IO_W-1:0];
        fgo  <= 1'b0;
      end else if (!fgo && out_ready) begin
        fgo  <= 1'b1;
      end
    end
  end

  assign in_ready  = ~fgi;
  assign out_valid = ~fgo;
  assign out_data  = outr;

  assign bus_out = bus;
  assign ac_out  = ac;
  assign dr_out  = dr;
  assign ir_out  = ir;
  assign pc_out  = pc;
  assign ar_out  = ar;
  assign e_out   = e;
  assign ien_out = ien;
  assign r_out   = r;
  assign fgi_out = fgi;
  assign fgo_out = fgo;

  assign ac_zero = (ac == '0);
  assign ac_neg  = ac[WORD-1];
  assign dr_zero = (dr == '0);

endmodule

// File: tb/tb_bc_datapath_io.sv
module tb_bc_datapath_io;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  sel_bus, sel_alu;
  logic [5:0]  ld, clr, inr;
  logic        mem_we, e_ld, e_clr, e_cme, ien_set, ien_clr;
  logic        int_sample, r_clr, fgi_clr, outr_ld;
  logic [7:0]  in_data;
  logic        in_valid, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic [15:0] bus_out, ac_out, dr_out, ir_out;
  logic [11:0] pc_out, ar_out;
  logic        e_out, ien_out, r_out, fgi_out, fgo_out;
  logic        ac_zero, ac_neg, dr_zero;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bc_datapath_io #(.WORD(16), .ADDRESS(12), .SIZE(4096), .IO_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .sel_bus(sel_bus), .sel_alu(sel_alu),
    .ld(ld), .clr(clr), .inr(inr), .mem_we(mem_we),
    .e_ld(e_ld), .e_clr(e_clr), .e_cme(e_cme),
    .ien_set(ien_set), .ien_clr(ien_clr), .int_sample(int_sample), .r_clr(r_clr),
    .fgi_clr(fgi_clr), .outr_ld(outr_ld),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .bus_out(bus_out), .ac_out(ac_out), .dr_out(dr_out), .ir_out(ir_out),
    .pc_out(pc_out), .ar_out(ar_out),
    .e_out(e_out), .ien_out(ien_out), .r_out(r_out), .fgi_out(fgi_out), .fgo_out(fgo_out),
    .ac_zero(ac_zero), .ac_neg(ac_neg), .dr_zero(dr_zero)
  );

  typedef struct {
    logic [2:0]  sb;
    logic [2:0]  sa;
    logic [5:0]  ld;
    logic [5:0]  clr;
    logic [5:0]  inr;
    logic [3:0]  f;     // {mem_we, e_ld, e_clr, e_cme}
    logic [15:0] bus;   // bus value before the edge
    logic [11:0] ar;
    logic [11:0] pc;
    logic [15:0] dr;
    logic [15:0] ac;
    logic [15:0] ir;
    logic        e;
  } vec_t;

  typedef struct {
    int          idx;
    logic [11:0] ar;
    logic [11:0] pc;
    logic [15:0] dr;
    logic [15:0] ac;
    logic [15:0] ir;
    logic        e;
  } exp_t;

  vec_t vt[$];
  exp_t sb_q[$];

  function automatic vec_t mk(input logic [2:0] sb, input logic [2:0] sa,
                              input logic [5:0] l, input logic [5:0] c, input logic [5:0] n,
                              input logic [3:0] f, input logic [15:0] bus,
                              input logic [11:0] ar, input logic [11:0] pc,
                              input logic [15:0] dr, input logic [15:0] ac,
                              input logic [15:0] ir, input logic e);
    vec_t v;
    v.sb = sb; v.sa = sa; v.ld = l; v.clr = c; v.inr = n; v.f = f; v.bus = bus;
    v.ar = ar; v.pc = pc; v.dr = dr; v.ac = ac; v.ir = ir; v.e = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    sel_bus = 0; sel_alu = 0; ld = 0; clr = 0; inr = 0; mem_we = 0;
    e_ld = 0; e_clr = 0; e_cme = 0; ien_set = 0; ien_clr = 0;
    int_sample = 0; r_clr = 0; fgi_clr = 0; outr_ld = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Load one input character into AC's low byte (FGI must be clear).
  task automatic take_char(input logic [7:0] ch);
    in_data = ch; in_valid = 1; cyc();
    in_valid = 0;
    sel_alu = 3; ld = 6'h08; cyc();
    idle();
  endtask

  initial begin
    exp_t x;
    idle();
    reset_n = 0; in_data = 0; in_valid = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    #1;
    chk("rst ac", ac_out, 16'h0);
    chk("rst pc", pc_out, 12'h0);
    chk("rst fgo", fgo_out, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst e/ien/r", {e_out, ien_out, r_out}, 3'b000);

    //          sb sa  ld     clr    inr    f        bus       ar      pc      dr        ac        ir        e
    vt.push_back(mk(0, 4, 6'h08, 6'h00, 6'h00, 4'b0000, 16'h0000, 12'h000, 12'h000, 16'h0000, 16'hFFFF, 16'h0000, 0));
    vt.push_back(mk(0, 0, 6'h00, 6'h00, 6'h04, 4'b0000, 16'h0000, 12'h000, 12'h000, 16'h0001, 16'hFFFF, 16'h0000, 0));
    vt.push_back(mk(0, 1, 6'h08, 6'h00, 6'h00, 4'b0100, 16'h0000, 12'h000, 12'h000, 16'h0001, 16'h0000, 16'h0000, 1));
    vt.push_back(mk(0, 0, 6'h00, 6'h00, 6'h00, 4'b0001, 16'h0000, 12'h000, 12'h000, 16'h0001, 16'h0000, 16'h0000, 0));
    vt.push_back(mk(0, 1, 6'h00, 6'h00, 6'h00, 4'b0101, 16'h0000, 12'h000, 12'h000, 16'h0001, 16'h0000, 16'h0000, 1));
    vt.push_back(mk(0, 0, 6'h00, 6'h00, 6'h00, 4'b0011, 16'h0000, 12'h000, 12'h000, 16'h0001, 16'h0000, 16'h0000, 0));
    vt.push_back(mk(0, 4, 6'h08, 6'h00, 6'h00, 4'b0000, 16'h0000, 12'h000, 12'h000, 16'h0001, 16'hFFFF, 16'h0000, 0));
    vt.push_back(mk(0, 6, 6'h08, 6'h00, 6'h00, 4'b0100, 16'h0000, 12'h000, 12'h000, 16'h0001, 16'hFFFE, 16'h0000, 1));
    vt.push_back(mk(0, 5, 6'h08, 6'h00, 6'h00, 4'b0100, 16'h0000, 12'h000, 12'h000, 16'h0001, 16'hFFFF, 16'h0000, 0));
    vt.push_back(mk(4, 0, 6'h03, 6'h00, 6'h00, 4'b0000, 16'hFFFF, 12'hFFF, 12'hFFF, 16'h0001, 16'hFFFF, 16'h0000, 0));
    vt.push_back(mk(0, 0, 6'h00, 6'h00, 6'h03, 4'b0000, 16'h0000, 12'h000, 12'h000, 16'h0001, 16'hFFFF, 16'h0000, 0));
    vt.push_back(mk(0, 0, 6'h08, 6'h00, 6'h04, 4'b0000, 16'h0000, 12'h000, 12'h000, 16'h0002, 16'h0001, 16'h0000, 0));
    vt.push_back(mk(0, 1, 6'h08, 6'h00, 6'h00, 4'b0000, 16'h0000, 12'h000, 12'h000, 16'h0002, 16'h0003, 16'h0000, 0));
    vt.push_back(mk(0, 1, 6'h08, 6'h00, 6'h00, 4'b0000, 16'h0000, 12'h000, 12'h000, 16'h0002, 16'h0005, 16'h0000, 0));
    vt.push_back(mk(4, 0, 6'h04, 6'h00, 6'h00, 4'b0000, 16'h0005, 12'h000, 12'h000, 16'h0005, 16'h0005, 16'h0000, 0));
    vt.push_back(mk(3, 0, 6'h02, 6'h00, 6'h02, 4'b0000, 16'h0005, 12'h000, 12'h005, 16'h0005, 16'h0005, 16'h0000, 0));
    vt.push_back(mk(3, 0, 6'h02, 6'h02, 6'h02, 4'b0000, 16'h0005, 12'h000, 12'h000, 16'h0005, 16'h0005, 16'h0000, 0));
    vt.push_back(mk(0, 4, 6'h08, 6'h08, 6'h00, 4'b0000, 16'h0000, 12'h000, 12'h000, 16'h0005, 16'h0000, 16'h0000, 0));
    vt.push_back(mk(0, 2, 6'h08, 6'h00, 6'h00, 4'b0000, 16'h0000, 12'h000, 12'h000, 16'h0005, 16'h0005, 16'h0000, 0));
    vt.push_back(mk(3, 0, 6'h01, 6'h00, 6'h00, 4'b0000, 16'h0005, 12'h005, 12'h000, 16'h0005, 16'h0005, 16'h0000, 0));
    vt.push_back(mk(0, 4, 6'h08, 6'h00, 6'h00, 4'b0000, 16'h0000, 12'h005, 12'h000, 16'h0005, 16'hFFFA, 16'h0000, 0));
    vt.push_back(mk(4, 0, 6'h00, 6'h00, 6'h00, 4'b1000, 16'hFFFA, 12'h005, 12'h000, 16'h0005, 16'hFFFA, 16'h0000, 0));
    vt.push_back(mk(0, 0, 6'h00, 6'h08, 6'h00, 4'b0000, 16'h0000, 12'h005, 12'h000, 16'h0005, 16'h0000, 16'h0000, 0));
    vt.push_back(mk(7, 0, 6'h04, 6'h00, 6'h00, 4'b0000, 16'hFFFA, 12'h005, 12'h000, 16'hFFFA, 16'h0000, 16'h0000, 0));
    vt.push_back(mk(7, 0, 6'h10, 6'h00, 6'h00, 4'b0000, 16'hFFFA, 12'h005, 12'h000, 16'hFFFA, 16'h0000, 16'hFFFA, 0));
    vt.push_back(mk(1, 0, 6'h20, 6'h00, 6'h00, 4'b0000, 16'h0005, 12'h005, 12'h000, 16'hFFFA, 16'h0000, 16'hFFFA, 0));
    vt.push_back(mk(6, 0, 6'h04, 6'h00, 6'h00, 4'b0000, 16'h0005, 12'h005, 12'h000, 16'h0005, 16'h0000, 16'hFFFA, 0));
    vt.push_back(mk(0, 1, 6'h08, 6'h00, 6'h00, 4'b0100, 16'h0000, 12'h005, 12'h000, 16'h0005, 16'h0005, 16'hFFFA, 0));

    for (int i = 0; i < vt.size(); i++) begin
      sel_bus = vt[i].sb; sel_alu = vt[i].sa;
      ld = vt[i].ld; clr = vt[i].clr; inr = vt[i].inr;
      {mem_we, e_ld, e_clr, e_cme} = vt[i].f;
      x.idx = i; x.ar = vt[i].ar; x.pc = vt[i].pc; x.dr = vt[i].dr;
      x.ac = vt[i].ac; x.ir = vt[i].ir; x.e = vt[i].e;
      sb_q.push_back(x);
      #1;
      chk($sformatf("v%0d bus", i), bus_out, vt[i].bus);
      cyc();
      x = sb_q.pop_front();
      chk($sformatf("v%0d ar", x.idx), ar_out, x.ar);
      chk($sformatf("v%0d pc", x.idx), pc_out, x.pc);
      chk($sformatf("v%0d dr", x.idx), dr_out, x.dr);
      chk($sformatf("v%0d ac", x.idx), ac_out, x.ac);
      chk($sformatf("v%0d ir", x.idx), ir_out, x.ir);
      chk($sformatf("v%0d e", x.idx), e_out, x.e);
      chk($sformatf("v%0d flags", x.idx), {ac_zero, ac_neg, dr_zero},
          {x.ac == 16'h0, x.ac[15], x.dr == 16'h0});
    end
    idle();

    // Input handshake: second character held off until FGI is cleared.
    clr = 6'h08; cyc(); idle();
    in_data = 8'h41; in_valid = 1; cyc();
    chk("in fgi set", fgi_out, 1);
    chk("in ready low", in_ready, 0);
    in_data = 8'h77; sel_alu = 3; ld = 6'h08; cyc();
    chk("inp ac", ac_out, 16'h0041);
    cyc();
    chk("inp held ac", ac_out, 16'h0041);
    chk("inp held fgi", fgi_out, 1);
    idle(); fgi_clr = 1; cyc(); fgi_clr = 0;
    chk("fgi_clr", fgi_out, 0);
    chk("fgi_clr ready", in_ready, 1);
    cyc();
    in_valid = 0;
    chk("second accept", fgi_out, 1);
    sel_alu = 3; ld = 6'h08; cyc(); idle();
    chk("second char ac", ac_out, 16'h0077);
    fgi_clr = 1; cyc(); cyc(); fgi_clr = 0;
    chk("fgi_clr noop", fgi_out, 0);

    // Output handshake.
    take_char(8'h42);
    chk("ac 0042", ac_out, 16'h0042);
    outr_ld = 1; cyc(); idle();
    chk("out valid", out_valid, 1);
    chk("out data", out_data, 8'h42);
    sel_alu = 4; ld = 6'h08; cyc(); idle();
    outr_ld = 1; cyc(); idle();
    chk("out 2nd ld ignored", out_data, 8'h42);
    chk("out still valid", out_valid, 1);
    out_ready = 1; cyc(); out_ready = 0;
    chk("out drained fgo", fgo_out, 1);
    chk("out drained valid", out_valid, 0);

    // Interrupt request (FGI=1, FGO=1 here).
    ien_set = 1; cyc(); idle();
    chk("ien set", ien_out, 1);
    int_sample = 1; cyc(); idle();
    chk("r set", r_out, 1);
    int_sample = 1; r_clr = 1; cyc(); idle();
    chk("r_clr wins", r_out, 0);
    ien_set = 1; ien_clr = 1; cyc(); idle();
    chk("ien_clr wins", ien_out, 0);
    int_sample = 1; cyc(); idle();
    chk("r needs ien", r_out, 0);

    // Build AC=0x1234 with a character pending, then reset mid-cycle.
    fgi_clr = 1; clr = 6'h08; e_clr = 1; cyc(); idle();
    take_char(8'h12);
    for (int k = 0; k < 8; k++) begin
      sel_alu = 6; ld = 6'h08; cyc();
    end
    idle();
    fgi_clr = 1; cyc(); idle();
    take_char(8'h34);
    chk("ac 1234", ac_out, 16'h1234);
    outr_ld = 1; cyc(); idle();
    chk("pre-rst fgo", fgo_out, 0);
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("async rst ac", ac_out, 16'h0);
    chk("async rst fgo", fgo_out, 1);
    chk("async rst out_valid", out_valid, 0);
    chk("async rst in_ready", in_ready, 1);
    chk("async rst out_data", out_data, 8'h00);
    chk("async rst dr/ir", {dr_out, ir_out}, 32'h0);
    @(posedge clk);
    #1 reset_n = 1;
    inr = 6'h01;
    repeat (5) cyc();
    idle();
    sel_bus = 7; #1;
    chk("mem kept over rst", bus_out, 16'hFFFA);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
